duc_mix_sched: RTL and testbench

Per-carrier NCO scheduler for the DUC frequency-shift mixer `multi_freq`. It sits directly in front of `multi_freq`, which is shared across NUM_CA time-division-multiplexed carriers. The block tracks the carrier slot of each input sample and keeps one phase accumulator per carrier. It generates the matching sin/cos coefficients and forwards I/Q, vld and ca delayed so that data and coefficients reach the mixer in the same cycle. Per-carrier frequency words and enables are reconfigured through a shadowed interface that applies only at frame boundaries.

---
 rtl/duc_pkg.sv | 43 ++++
 rtl/mix_sincos_lut.sv | 63 ++++++
 rtl/duc_mix_sched.sv | 149 ++++++++++++++
 tb/tb_duc_mix_sched.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/duc_pkg.sv
// Shared defaults and types for the DUC per-carrier NCO scheduler.
// The quadrant helpers describe how a quarter-wave table folds onto a full sine cycle.
package duc_pkg;

  localparam int NUM_CA_DEF = 4;
  localparam int PW_DEF     = 24;
  localparam int LUT_AW_DEF = 8;
  localparam int AMP_DEF    = 1023;

  typedef logic [$clog2(NUM_CA_DEF)-1:0] slot_t;

  typedef enum logic [1:0] {
    QUAD_0 = 2'd0,
    QUAD_1 = 2'd1,
    QUAD_2 = 2'd2,
    QUAD_3 = 2'd3
  } quad_t;

  typedef struct packed {
    logic mirror;
    logic neg;
  } fold_t;

  // Odd quadrants walk the table backwards, the lower half-cycle is negated.
  function automatic fold_t quad_fold(input quad_t q);
    fold_t f;
    f.mirror = (q == QUAD_1) || (q == QUAD_3);
    f.neg    = (q == QUAD_2) || (q == QUAD_3);
    return f;
  endfunction

  function automatic quad_t quad_next(input quad_t q);
    quad_t n;
    unique case (q)
      QUAD_0:  n = QUAD_1;
      QUAD_1:  n = QUAD_2;
      QUAD_2:  n = QUAD_3;
      default: n = QUAD_0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mix_sincos_lut.sv
// Quarter-wave sine ROM with quadrant fold: decode stage, then table read and sign fold.
// Produces registered sin/cos two cycles after the phase is presented.
module mix_sincos_lut
  import duc_pkg::*;
#(
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int AMP    = AMP_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [LUT_AW+1:0] phase_i,
  input  logic              en_i,
  output logic [15:0]       sin_o,
  output logic [15:0]       cos_o
);

  localparam int  DEPTH = 2 ** LUT_AW;
  localparam real PI    = 3.14159265358979323846;

  logic [15:0] rom [DEPTH];

  // Half-step offset keeps the table symmetric so mirroring by ~addr is exact.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
    localparam int VAL = $rtoi(AMP * $sin((gi + 0.5) * PI / (2.0 ** (LUT_AW + 1))) + 0.5);
    assign rom[gi] = 16'(VAL);
  end

  quad_t             quad_q;
  logic [LUT_AW-1:0] addr_q;
  logic              en_q;
  fold_t             sin_f, cos_f;
  logic [15:0]       sin_mag, cos_mag;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      quad_q <= QUAD_0;
      addr_q <= '0;
      en_q   <= 1'b0;
    end else begin
      quad_q <= quad_t'(phase_i[LUT_AW+1:LUT_AW]);
      addr_q <= phase_i[LUT_AW-1:0];
      en_q   <= en_i;
    end
  end

  always_comb begin
    sin_f   = quad_fold(quad_q);
    cos_f   = quad_fold(quad_next(quad_q));
    sin_mag = rom[sin_f.mirror ? ~addr_q : addr_q];
    cos_mag = rom[cos_f.mirror ? ~addr_q : addr_q];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sin_o <= '0;
      cos_o <= '0;
    end else begin
      sin_o <= !en_q ? '0 : (sin_f.neg ? -sin_mag : sin_mag);
      cos_o <= !en_q ? '0 : (cos_f.neg ? -cos_mag : cos_mag);
    end
  end

endmodule

// File: rtl/duc_mix_sched.sv
// Per-carrier NCO scheduler for a TDM-shared frequency-shift mixer.
// Tracks the carrier slot, keeps one phase accumulator per carrier and aligns data with sin/cos.
module duc_mix_sched
  import duc_pkg::*;
#(
  parameter int NUM_CA = NUM_CA_DEF,
  parameter int PW     = PW_DEF,
  parameter int LUT_AW = LUT_AW_DEF,
  parameter int AMP    = AMP_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_data_vld,
  input  logic                      i_data_ca,
  input  logic [15:0]               i_data_i,
  input  logic [15:0]               i_data_q,
  input  logic                      i_cfg_we,
  input  logic [$clog2(NUM_CA)-1:0] i_cfg_ca,
  input  logic [PW-1:0]             i_cfg_fcw,
  input  logic                      i_cfg_en,
  input  logic                      i_sync_clr,
  output logic                      o_cfg_pend,
  output logic                      o_slot_err,
  output logic                      o_data_vld,
  output logic                      o_data_ca,
  output logic [15:0]               o_data_i,
  output logic [15:0]               o_data_q,
  output logic [15:0]               o_sin_coff,
  output logic [15:0]               o_cos_coff
);

  localparam int SW  = $clog2(NUM_CA);
  localparam int PHW = LUT_AW + 2;
  localparam int DLY = 3;

  logic [SW-1:0]     slot_q, slot_d, cur_slot;
  logic              started_q, wr_pend_q, clr_pend_q, err_q;
  logic [PW-1:0]     acc_q     [NUM_CA];
  logic [PW-1:0]     fcw_act_q [NUM_CA];
  logic [PW-1:0]     fcw_sh_q  [NUM_CA];
  logic [PW-1:0]     fcw_new   [NUM_CA];
  logic [NUM_CA-1:0] en_act_q, en_sh_q, en_new;
  logic [PHW-1:0]    phase_q;
  logic              en_s1_q;
  logic              bnd, clr_now;
  logic [DLY-1:0]    vld_dly_q, ca_dly_q;
  logic [15:0]       i_dly_q [DLY];
  logic [15:0]       q_dly_q [DLY];

  assign bnd      = i_data_vld & i_data_ca;
  assign clr_now  = bnd & clr_pend_q;
  assign cur_slot = i_data_ca ? '0 : slot_q;
  assign slot_d   = (cur_slot == SW'(NUM_CA - 1)) ? '0 : cur_slot + SW'(1);
  // At a frame start the shadow values take effect for the very sample that carries ca.
  assign en_new   = bnd ? en_sh_q : en_act_q;

  for (genvar gi = 0; gi < NUM_CA; gi++) begin : g_fcw
    assign fcw_new[gi] = bnd ? fcw_sh_q[gi] : fcw_act_q[gi];
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      slot_q     <= '0;
      started_q  <= 1'b0;
      wr_pend_q  <= 1'b0;
      clr_pend_q <= 1'b0;
      err_q      <= 1'b0;
      en_act_q   <= '1;
      en_sh_q    <= '1;
      phase_q    <= '0;
      en_s1_q    <= 1'b0;
      for (int c = 0; c < NUM_CA; c++) begin
        acc_q[c]     <= '0;
        fcw_act_q[c] <= '0;
        fcw_sh_q[c]  <= '0;
      end
    end else begin
      err_q   <= bnd & started_q & (slot_q != '0);
      en_s1_q <= i_data_vld & en_new[cur_slot];
      if (i_data_vld) begin
        slot_q  <= slot_d;
        phase_q <= clr_now ? '0 : acc_q[cur_slot][PW-1 -: PHW];
      end
      if (bnd) begin
        started_q  <= 1'b1;
        fcw_act_q  <= fcw_sh_q;
        en_act_q   <= en_sh_q;
        wr_pend_q  <= 1'b0;
        clr_pend_q <= 1'b0;
      end
      // A write or clear landing on the boundary cycle waits for the following frame.
      if (i_cfg_we) begin
        fcw_sh_q[i_cfg_ca] <= i_cfg_fcw;
        en_sh_q[i_cfg_ca]  <= i_cfg_en;
        wr_pend_q          <= 1'b1;
      end
      if (i_sync_clr) begin
        clr_pend_q <= 1'b1;
      end
      for (int c = 0; c < NUM_CA; c++) begin
        if (clr_now) begin
          acc_q[c] <= (c == 0) ? fcw_new[0] : '0;
        end else if (i_data_vld && (cur_slot == SW'(c))) begin
          acc_q[c] <= acc_q[c] + fcw_new[c];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      vld_dly_q <= '0;
      ca_dly_q  <= '0;
      for (int k = 0; k < DLY; k++) begin
        i_dly_q[k] <= '0;
        q_dly_q[k] <= '0;
      end
    end else begin
      vld_dly_q  <= {vld_dly_q[DLY-2:0], i_data_vld};
      ca_dly_q   <= {ca_dly_q[DLY-2:0], i_data_ca};
      i_dly_q[0] <= i_data_i;
      q_dly_q[0] <= i_data_q;
      for (int k = 1; k < DLY; k++) begin
        i_dly_q[k] <= i_dly_q[k-1];
        q_dly_q[k] <= q_dly_q[k-1];
      end
    end
  end

  mix_sincos_lut #(
    .LUT_AW (LUT_AW),
    .AMP    (AMP)
  ) u_lut (
    .clk_i   (i_clk),
    .rst_ni  (i_reset),
    .phase_i (phase_q),
    .en_i    (en_s1_q),
    .sin_o   (o_sin_coff),
    .cos_o   (o_cos_coff)
  );

  assign o_cfg_pend = wr_pend_q | clr_pend_q;
  assign o_slot_err = err_q;
  assign o_data_vld = vld_dly_q[DLY-1];
  assign o_data_ca  = ca_dly_q[DLY-1];
  assign o_data_i   = i_dly_q[DLY-1];
  assign o_data_q   = q_dly_q[DLY-1];

endmodule

// File: tb/tb_duc_mix_sched.sv
// Randomised self-checking bench for duc_mix_sched against a frame-level reference model.
// One line per checked output sample; explicit scenario checks live in each test task.
module tb_duc_mix_sched;
  import duc_pkg::*;

  localparam int NCA = 4;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_data_vld = 1'b0, i_data_ca = 1'b0;
  logic [15:0] i_data_i = '0, i_data_q = '0;
  logic        i_cfg_we = 1'b0;
  logic [1:0]  i_cfg_ca = '0;
  logic [23:0] i_cfg_fcw = '0;
  logic        i_cfg_en = 1'b1;
  logic        i_sync_clr = 1'b0;
  logic        o_cfg_pend, o_slot_err, o_data_vld, o_data_ca;
  logic [15:0] o_data_i, o_data_q, o_sin_coff, o_cos_coff;

  duc_mix_sched dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_data_vld(i_data_vld), .i_data_ca(i_data_ca),
    .i_data_i(i_data_i), .i_data_q(i_data_q),
    .i_cfg_we(i_cfg_we), .i_cfg_ca(i_cfg_ca), .i_cfg_fcw(i_cfg_fcw),
    .i_cfg_en(i_cfg_en), .i_sync_clr(i_sync_clr),
    .o_cfg_pend(o_cfg_pend), .o_slot_err(o_slot_err),
    .o_data_vld(o_data_vld), .o_data_ca(o_data_ca),
    .o_data_i(o_data_i), .o_data_q(o_data_q),
    .o_sin_coff(o_sin_coff), .o_cos_coff(o_cos_coff)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit        vld;
    bit        ca;
    bit [15:0] di;
    bit [15:0] dq;
    int        slot;
    bit [15:0] s;
    bit [15:0] c;
  } exp_t;

  exp_t pipe[$];
  exp_t pop_e;
  bit   popped;
  int   n_checks = 0;
  int   n_fail = 0;

  // Reference model state: one accumulator per carrier, active and shadow config.
  bit [23:0] m_acc[NCA];
  bit [23:0] m_fcw_act[NCA];
  bit [23:0] m_fcw_sh[NCA];
  bit        m_en_act[NCA];
  bit        m_en_sh[NCA];
  bit        m_wr_pend, m_clr_pend, m_started;
  int        m_slot;
  int        lut[256];

  function automatic bit [15:0] fold(input int q, input int a);
    int idx;
    int v;
    idx = (q % 2 == 1) ? 255 - a : a;
    v = lut[idx];
    if (q >= 2) v = -v;
    return 16'(v);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NCA; c++) begin
      m_acc[c] = '0; m_fcw_act[c] = '0; m_fcw_sh[c] = '0;
      m_en_act[c] = 1'b1; m_en_sh[c] = 1'b1;
    end
    m_wr_pend = 0; m_clr_pend = 0; m_started = 0; m_slot = 0;
    pipe.delete();
    for (int k = 0; k < 2; k++) begin
      exp_t z;
      z.vld = 0; z.ca = 0; z.di = 0; z.dq = 0; z.slot = -1; z.s = 0; z.c = 0;
      pipe.push_back(z);
    end
  endtask

  task automatic model_step(input bit vld, input bit ca, input bit [15:0] di, input bit [15:0] dq,
                            input bit we, input int cca, input bit [23:0] cfcw, input bit cen,
                            input bit clr, output exp_t e, output bit err);
    int s;
    bit [23:0] ph;
    err = 0;
    e.vld = vld; e.ca = ca; e.di = di; e.dq = dq; e.slot = -1; e.s = 0; e.c = 0;
    if (vld) begin
      if (ca) begin
        if (m_started && m_slot != 0) err = 1;
        m_started = 1;
        for (int c = 0; c < NCA; c++) begin
          m_fcw_act[c] = m_fcw_sh[c];
          m_en_act[c] = m_en_sh[c];
        end
        m_wr_pend = 0;
        s = 0;
        if (m_clr_pend) begin
          for (int c = 0; c < NCA; c++) m_acc[c] = '0;
          m_clr_pend = 0;
        end
      end else begin
        s = m_slot;
      end
      ph = m_acc[s];
      m_acc[s] = m_acc[s] + m_fcw_act[s];
      m_slot = (s + 1) % NCA;
      e.slot = s;
      if (m_en_act[s]) begin
        e.s = fold(int'(ph[23:22]), int'(ph[21:14]));
        e.c = fold((int'(ph[23:22]) + 1) % 4, int'(ph[21:14]));
      end
    end
    if (we) begin
      m_fcw_sh[cca] = cfcw;
      m_en_sh[cca] = cen;
      m_wr_pend = 1;
    end
    if (clr) m_clr_pend = 1;
  endtask

  // Drives one cycle, advances the model and scores the output sample leaving the pipe.
  task automatic tick(input bit vld, input bit ca, input bit we, input int cca,
                      input bit [23:0] cfcw, input bit cen, input bit clr);
    exp_t e;
    bit err;
    bit [15:0] di, dq;
    di = 16'($urandom);
    dq = 16'($urandom);
    i_data_vld = vld; i_data_ca = ca; i_data_i = di; i_data_q = dq;
    i_cfg_we = we; i_cfg_ca = 2'(cca); i_cfg_fcw = cfcw; i_cfg_en = cen; i_sync_clr = clr;
    @(posedge i_clk);
    model_step(vld, ca, di, dq, we, cca, cfcw, cen, clr, e, err);
    #1;
    i_cfg_we = 0; i_sync_clr = 0;
    n_checks++;
    if (o_slot_err !== err) begin
      n_fail++;
      $display("FAIL slot_err got %b exp %b", o_slot_err, err);
    end
    n_checks++;
    if (o_cfg_pend !== (m_wr_pend | m_clr_pend)) begin
      n_fail++;
      $display("FAIL cfg_pend got %b exp %b", o_cfg_pend, m_wr_pend | m_clr_pend);
    end
    pipe.push_back(e);
    popped = 0;
    if (pipe.size() >= 3) begin
      pop_e = pipe.pop_front();
      popped = 1;
      n_checks++;
      if ({o_data_vld, o_data_ca, o_data_i, o_data_q} !== {pop_e.vld, pop_e.ca, pop_e.di, pop_e.dq}) begin
        n_fail++;
        $display("FAIL data got vld=%b ca=%b i=%h q=%h exp vld=%b ca=%b i=%h q=%h",
                 o_data_vld, o_data_ca, o_data_i, o_data_q, pop_e.vld, pop_e.ca, pop_e.di, pop_e.dq);
      end
      if (pop_e.vld) begin
        n_checks++;
        if (o_sin_coff !== pop_e.s || o_cos_coff !== pop_e.c) begin
          n_fail++;
          $display("FAIL coeff slot=%0d got sin=%h cos=%h exp sin=%h cos=%h",
                   pop_e.slot, o_sin_coff, o_cos_coff, pop_e.s, pop_e.c);
        end else begin
          $display("ok slot=%0d ca=%b sin=%h cos=%h i=%h q=%h",
                   pop_e.slot, pop_e.ca, o_sin_coff, o_cos_coff, o_data_i, o_data_q);
        end
      end
    end
  endtask

  task automatic sample(input bit ca);
    tick(1, ca, 0, 0, 24'h0, 1, 0);
  endtask

  task automatic idle();
    tick(0, 0, 0, 0, 24'h0, 1, 0);
  endtask

  task automatic cfg(input int cca, input bit [23:0] fcw, input bit en);
    tick(0, 0, 1, cca, fcw, en, 0);
  endtask

  task automatic frame();
    sample(1);
    for (int k = 1; k < NCA; k++) sample(0);
  endtask

  task automatic flush();
    for (int k = 0; k < 3; k++) idle();
  endtask

  task automatic check_all_zero(input string tag);
    n_checks++;
    if ({o_cfg_pend, o_slot_err, o_data_vld, o_data_ca, o_data_i, o_data_q, o_sin_coff, o_cos_coff} !== '0) begin
      n_fail++;
      $display("FAIL %s got pend=%b err=%b vld=%b ca=%b i=%h q=%h sin=%h cos=%h exp all zero", tag,
               o_cfg_pend, o_slot_err, o_data_vld, o_data_ca, o_data_i, o_data_q, o_sin_coff, o_cos_coff);
    end
  endtask

  task automatic test_reset();
    i_data_vld = 1; i_data_ca = 1; i_data_i = 16'hAAAA; i_data_q = 16'h5555;
    i_reset = 0;
    repeat (3) @(posedge i_clk);
    #1;
    check_all_zero("reset_outputs");
    i_data_vld = 0; i_data_ca = 0;
    i_reset = 1;
    model_reset();
  endtask

  task automatic test_zero_fcw();
    frame();
    for (int k = 0; k < 3; k++) begin
      idle();
      if (popped && pop_e.vld) begin
        n_checks++;
        if (o_sin_coff !== 16'h0003 || o_cos_coff !== 16'h03FF) begin
          n_fail++;
          $display("FAIL zero_fcw got sin=%h cos=%h exp sin=0003 cos=03ff", o_sin_coff, o_cos_coff);
        end
      end
    end
  endtask

  task automatic test_fcw_slot1();
    bit [15:0] es[4] = '{16'h0003, 16'h03FF, 16'hFFFD, 16'hFC01};
    bit [15:0] ec[4] = '{16'h03FF, 16'hFFFD, 16'hFC01, 16'h0003};
    int n = 0;
    cfg(1, 24'h400000, 1);
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NCA; k++) begin
        sample(k == 0);
        if (popped && pop_e.vld && pop_e.slot == 1 && n < 4) begin
          n_checks++;
          if (o_sin_coff !== es[n] || o_cos_coff !== ec[n]) begin
            n_fail++;
            $display("FAIL fcw_slot1 frame=%0d got sin=%h cos=%h exp sin=%h cos=%h",
                     n, o_sin_coff, o_cos_coff, es[n], ec[n]);
          end
          n++;
        end
      end
    end
    for (int k = 0; k < 3; k++) begin
      idle();
      if (popped && pop_e.vld && pop_e.slot == 1 && n < 4) begin
        n_checks++;
        if (o_sin_coff !== es[n] || o_cos_coff !== ec[n]) begin
          n_fail++;
          $display("FAIL fcw_slot1 frame=%0d got sin=%h cos=%h exp sin=%h cos=%h",
                   n, o_sin_coff, o_cos_coff, es[n], ec[n]);
        end
        n++;
      end
    end
    n_checks++;
    if (n != 4) begin
      n_fail++;
      $display("FAIL fcw_slot1_count got %0d exp 4", n);
    end
  endtask

  task automatic test_cfg_same_cycle();
    tick(1, 1, 1, 3, 24'h123456, 1, 0);
    n_checks++;
    if (o_cfg_pend !== 1'b1) begin
      n_fail++;
      $display("FAIL pend_first_boundary got %b exp 1", o_cfg_pend);
    end
    for (int k = 1; k < NCA; k++) sample(0);
    sample(1);
    n_checks++;
    if (o_cfg_pend !== 1'b0) begin
      n_fail++;
      $display("FAIL pend_second_boundary got %b exp 0", o_cfg_pend);
    end
    for (int k = 1; k < NCA; k++) sample(0);
    frame();
    flush();
  endtask

  task automatic test_disable();
    cfg(2, 24'h080000, 0);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < NCA; k++) begin
        sample(k == 0);
        if (popped && pop_e.vld && pop_e.slot == 2) begin
          n_checks++;
          if (o_sin_coff !== 16'h0 || o_cos_coff !== 16'h0) begin
            n_fail++;
            $display("FAIL disabled_slot2 got sin=%h cos=%h exp 0000 0000", o_sin_coff, o_cos_coff);
          end
        end
      end
    end
    flush();
    cfg(2, 24'h080000, 1);
    repeat (3) frame();
    flush();
  endtask

  task automatic test_slot_err();
    sample(1);
    sample(0);
    sample(1);
    n_checks++;
    if (o_slot_err !== 1'b1) begin
      n_fail++;
      $display("FAIL short_frame_err got %b exp 1", o_slot_err);
    end
    sample(0);
    n_checks++;
    if (o_slot_err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_single_pulse got %b exp 0", o_slot_err);
    end
    sample(0);
    sample(0);
    sample(1);
    n_checks++;
    if (o_slot_err !== 1'b0) begin
      n_fail++;
      $display("FAIL full_frame_no_err got %b exp 0", o_slot_err);
    end
    for (int k = 1; k < NCA; k++) sample(0);
    flush();
  endtask

  task automatic test_sync_clr();
    cfg(0, 24'h012345, 1);
    cfg(3, 24'h300001, 1);
    repeat (2) frame();
    tick(0, 0, 0, 0, 24'h0, 1, 1);
    n_checks++;
    if (o_cfg_pend !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_pend got %b exp 1", o_cfg_pend);
    end
    for (int f = 0; f < 2; f++) begin
      for (int k = 0; k < NCA; k++) sample(k == 0);
    end
    for (int k = 0; k < 3; k++) idle();
    repeat (3) frame();
    flush();
  endtask

  task automatic test_sync_clr_slot0();
    int seen = 0;
    tick(0, 0, 0, 0, 24'h0, 1, 1);
    sample(1);
    for (int k = 0; k < 4; k++) begin
      if (k < NCA - 1) sample(0); else idle();
      if (popped && pop_e.vld && pop_e.ca && seen == 0) begin
        seen = 1;
        n_checks++;
        if (o_sin_coff !== 16'h0003 || o_cos_coff !== 16'h03FF) begin
          n_fail++;
          $display("FAIL clr_slot0 got sin=%h cos=%h exp sin=0003 cos=03ff", o_sin_coff, o_cos_coff);
        end
      end
    end
    flush();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      bit vld, ca, we, en, clr;
      vld = ($urandom_range(0, 3) != 0);
      ca = vld && ((m_slot == 0 && $urandom_range(0, 7) != 0) || $urandom_range(0, 15) == 0);
      we = ($urandom_range(0, 9) == 0);
      en = ($urandom_range(0, 4) != 0);
      clr = ($urandom_range(0, 39) == 0);
      tick(vld, ca, we, int'($urandom_range(0, NCA - 1)), 24'($urandom), en, clr);
    end
    flush();
  endtask

  task automatic test_reset_mid();
    sample(1);
    tick(1, 0, 1, 2, 24'h00ABCD, 0, 1);
    sample(0);
    i_reset = 0;
    #2;
    check_all_zero("reset_mid_outputs");
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1;
    model_reset();
    n_checks++;
    if (o_cfg_pend !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discards_pend got %b exp 0", o_cfg_pend);
    end
  endtask

  task automatic test_back_to_back();
    sample(0);
    sample(0);
    sample(1);
    n_checks++;
    if (o_slot_err !== 1'b0) begin
      n_fail++;
      $display("FAIL first_ca_no_err got %b exp 0", o_slot_err);
    end
    for (int k = 1; k < NCA; k++) sample(0);
    cfg(1, 24'h0F0F0F, 1);
    repeat (5) frame();
    flush();
  endtask

  initial begin
    for (int k = 0; k < 256; k++)
      lut[k] = $rtoi(1023.0 * $sin((k + 0.5) * 3.14159265358979323846 / 512.0) + 0.5);
    test_reset();
    test_zero_fcw();
    test_fcw_slot1();
    test_cfg_same_cycle();
    test_disable();
    test_slot_err();
    test_sync_clr();
    test_sync_clr_slot0();
    test_random();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
